// File: rtl/goose_loader_if.sv
// Byte-stream input and memory-write output bundle for goose_loader.
// slave = loader side, master = host/memory side.
interface goose_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       wr_en;
  logic       wr_sel;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] err_code;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err, err_code
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err, err_code
  );
endinterface

// File: rtl/goose_loader.sv
// Parses CMD / ADDR / LEN / data / checksum frames from a byte stream into
// sprite-index or palette memory writes, with bounds, checksum and idle-timeout checks.
module goose_loader #(
  parameter int unsigned SPRITE_DEPTH   = 1024,
  parameter int unsigned PALETTE_DEPTH  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  goose_loader_if.slave bus
);
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned EW = 3;
  localparam int unsigned SW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0] CMD_SPRITE  = 8'hA5;
  localparam logic [DW-1:0] CMD_PALETTE = 8'h5A;
  localparam logic [EW-1:0] E_CMD       = 3'd1;
  localparam logic [EW-1:0] E_BOUNDS    = 3'd2;
  localparam logic [EW-1:0] E_CHK       = 3'd3;
  localparam logic [EW-1:0] E_TIMEOUT   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_sel, w_sel_nx;
  logic [AW-1:0]   r_ptr, w_ptr_nx;
  logic [AW-1:0]   r_len, w_len_nx;
  logic            r_addr_bad, w_addr_bad_nx;
  logic [DW-1:0]   r_sum, w_sum_nx;
  logic [TW-1:0]   r_tcnt, w_tcnt_nx;
  logic            r_rx_ready, w_rx_ready_nx;
  logic            r_wr_en, w_wr_en_nx;
  logic [AW-1:0]   r_wr_addr, w_wr_addr_nx;
  logic [DW-1:0]   r_wr_data, w_wr_data_nx;
  logic            r_busy, w_busy_nx;
  logic            r_done, w_done_nx;
  logic            r_err, w_err_nx;
  logic [EW-1:0]   r_err_code, w_err_code_nx;

  logic            w_accept;
  logic [AW-1:0]   w_len_full;
  logic [SW-1:0]   w_end;
  logic [SW-1:0]   w_depth;

  assign w_accept   = bus.rx_valid && r_rx_ready;
  assign w_len_full = {bus.rx_data[1:0], r_len[7:0]};
  // r_ptr still holds the frame start address while in LEN_HI
  assign w_end      = {1'b0, r_ptr} + {1'b0, w_len_full};
  assign w_depth    = r_sel ? SW'(PALETTE_DEPTH) : SW'(SPRITE_DEPTH);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nx    = r_state;
    w_sel_nx      = r_sel;
    w_ptr_nx      = r_ptr;
    w_len_nx      = r_len;
    w_addr_bad_nx = r_addr_bad;
    w_sum_nx      = r_sum;
    w_tcnt_nx     = '0;
    w_rx_ready_nx = 1'b1;
    w_wr_en_nx    = 1'b0;
    w_wr_addr_nx  = r_wr_addr;
    w_wr_data_nx  = r_wr_data;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;
    w_err_code_nx = r_err_code;

    if (r_state != S_IDLE && !w_accept) begin
      if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        w_state_nx    = S_IDLE;
        w_err_nx      = 1'b1;
        w_err_code_nx = E_TIMEOUT;
        w_rx_ready_nx = 1'b0;
      end else begin
        w_tcnt_nx = r_tcnt + TW'(1);
      end
    end

    if (w_accept) begin
      if (r_state != S_IDLE) w_sum_nx = r_sum + bus.rx_data;
      unique case (r_state)
        S_IDLE: begin
          if (bus.rx_data == CMD_SPRITE || bus.rx_data == CMD_PALETTE) begin
            w_state_nx    = S_ADDR_LO;
            w_sel_nx      = (bus.rx_data == CMD_PALETTE);
            w_sum_nx      = '0;
            w_err_code_nx = '0;
          end else begin
            w_err_nx      = 1'b1;
            w_err_code_nx = E_CMD;
          end
        end
        S_ADDR_LO: begin
          w_ptr_nx   = {2'b00, bus.rx_data};
          w_state_nx = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          w_ptr_nx      = {bus.rx_data[1:0], r_ptr[7:0]};
          w_addr_bad_nx = |bus.rx_data[7:2];
          w_state_nx    = S_LEN_LO;
        end
        S_LEN_LO: begin
          w_len_nx   = {2'b00, bus.rx_data};
          w_state_nx = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (w_len_full == '0 || r_addr_bad || (|bus.rx_data[7:2]) || w_end > w_depth) begin
            w_state_nx    = S_IDLE;
            w_err_nx      = 1'b1;
            w_err_code_nx = E_BOUNDS;
            w_rx_ready_nx = 1'b0;
          end else begin
            w_len_nx   = w_len_full;
            w_state_nx = S_DATA;
          end
        end
        S_DATA: begin
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = r_ptr;
          w_wr_data_nx = bus.rx_data;
          w_ptr_nx     = r_ptr + AW'(1);
          w_len_nx     = r_len - AW'(1);
          if (r_len == AW'(1)) w_state_nx = S_CHECK;
        end
        S_CHECK: begin
          w_state_nx    = S_IDLE;
          w_rx_ready_nx = 1'b0;
          if (bus.rx_data == r_sum) begin
            w_done_nx = 1'b1;
          end else begin
            w_err_nx      = 1'b1;
            w_err_code_nx = E_CHK;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_ptr      <= '0;
      r_len      <= '0;
      r_addr_bad <= 1'b0;
      r_sum      <= '0;
      r_tcnt     <= '0;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_sel      <= w_sel_nx;
      r_ptr      <= w_ptr_nx;
      r_len      <= w_len_nx;
      r_addr_bad <= w_addr_bad_nx;
      r_sum      <= w_sum_nx;
      r_tcnt     <= w_tcnt_nx;
      r_rx_ready <= w_rx_ready_nx;
      r_wr_en    <= w_wr_en_nx;
      r_wr_addr  <= w_wr_addr_nx;
      r_wr_data  <= w_wr_data_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
      r_err_code <= w_err_code_nx;
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_sel   = r_sel;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
endmodule

// File: tb/tb_goose_loader.sv
// Directed and randomized frames for goose_loader, checked against a frame-level
// model that predicts every write, done/err pulse and the cycle it lands on.
module tb_goose_loader;
  localparam int unsigned T = 16;

  typedef logic [7:0] bq_t [$];
  typedef int iq_t [$];
  typedef struct packed { logic sel; logic [9:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct packed { logic done; logic err; logic [2:0] code; logic rdy; logic busy; int cyc; } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wr_t obs_wr[$], exp_wr[$];
  ev_t obs_ev[$], exp_ev[$];

  goose_loader_if bus ();

  goose_loader #(.SPRITE_DEPTH(1024), .PALETTE_DEPTH(256), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Record every write and status pulse with the cycle it is visible in
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1)
      obs_wr.push_back('{bus.wr_sel, bus.wr_addr, bus.wr_data, cyc});
    if (bus.done === 1'b1 || bus.err === 1'b1) begin
      obs_ev.push_back('{bus.done, bus.err, bus.err_code, bus.rx_ready, bus.busy, cyc});
      chk("wr_en_during_evt", 32'(bus.wr_en), 32'd0);
    end
  end

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int n;
    n = 0;
    idle(gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    chk("rdy_wait", 32'(n < 8), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    bus.rx_valid = 1'b0;
  endtask

  function automatic void push_ev(input logic d, input logic [2:0] c, input int cy);
    exp_ev.push_back('{d, !d, d ? 3'd0 : c, (!d && c == 3'd1), 1'b0, cy});
  endfunction

  // Frame-level reference: one frame (or one stray byte) per call
  function automatic void model(input bq_t b, input iq_t acc);
    int n;
    int unsigned addr, len, depth, sum;
    logic sel;
    n = b.size();
    if (n == 0) return;
    if (b[0] != 8'hA5 && b[0] != 8'h5A) begin push_ev(1'b0, 3'd1, acc[0]); return; end
    sel   = (b[0] == 8'h5A);
    depth = sel ? 256 : 1024;
    if (n < 5) begin push_ev(1'b0, 3'd4, acc[n-1] + int'(T)); return; end
    addr = int'(b[1]) + 256 * int'(b[2]);
    len  = int'(b[3]) + 256 * int'(b[4]);
    if (len == 0 || addr > 1023 || len > 1023 || addr + len > depth) begin
      push_ev(1'b0, 3'd2, acc[4]);
      return;
    end
    sum = int'(b[1]) + int'(b[2]) + int'(b[3]) + int'(b[4]);
    for (int k = 0; k < int'(len) && 5 + k < n; k++) begin
      exp_wr.push_back('{sel, 10'(addr + k), b[5+k], acc[5+k]});
      sum += int'(b[5+k]);
    end
    if (n < 6 + int'(len)) push_ev(1'b0, 3'd4, acc[n-1] + int'(T));
    else if (b[5+len] == 8'(sum)) push_ev(1'b1, 3'd0, acc[5+len]);
    else push_ev(1'b0, 3'd3, acc[5+len]);
  endfunction

  function automatic bq_t gen_frame(input logic sel, input int unsigned addr,
                                    input int unsigned len, input bit corrupt);
    bq_t b;
    int unsigned s;
    logic [7:0] d;
    b.push_back(sel ? 8'h5A : 8'hA5);
    b.push_back(8'(addr));
    b.push_back(8'(addr >> 8));
    b.push_back(8'(len));
    b.push_back(8'(len >> 8));
    s = int'(b[1]) + int'(b[2]) + int'(b[3]) + int'(b[4]);
    for (int k = 0; k < int'(len); k++) begin
      d = 8'($urandom);
      b.push_back(d);
      s += int'(d);
    end
    b.push_back(8'(s) ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'd0));
    return b;
  endfunction

  task automatic check_frame(input string tag);
    int nw, ne;
    chk({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    nw = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < nw; i++) begin
      chk({tag, "_wr_sel"},  32'(obs_wr[i].sel),  32'(exp_wr[i].sel));
      chk({tag, "_wr_addr"}, 32'(obs_wr[i].addr), 32'(exp_wr[i].addr));
      chk({tag, "_wr_data"}, 32'(obs_wr[i].data), 32'(exp_wr[i].data));
      chk({tag, "_wr_cyc"},  32'(obs_wr[i].cyc),  32'(exp_wr[i].cyc));
    end
    chk({tag, "_nevt"}, 32'(obs_ev.size()), 32'(exp_ev.size()));
    ne = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < ne; i++) begin
      chk({tag, "_ev_done"}, 32'(obs_ev[i].done), 32'(exp_ev[i].done));
      chk({tag, "_ev_err"},  32'(obs_ev[i].err),  32'(exp_ev[i].err));
      chk({tag, "_ev_code"}, 32'(obs_ev[i].code), 32'(exp_ev[i].code));
      chk({tag, "_ev_rdy"},  32'(obs_ev[i].rdy),  32'(exp_ev[i].rdy));
      chk({tag, "_ev_busy"}, 32'(obs_ev[i].busy), 32'(exp_ev[i].busy));
      chk({tag, "_ev_cyc"},  32'(obs_ev[i].cyc),  32'(exp_ev[i].cyc));
    end
    obs_wr.delete(); exp_wr.delete(); obs_ev.delete(); exp_ev.delete();
  endtask

  task automatic run_frame(input string tag, input bq_t b, input int gapmax);
    iq_t acc;
    int a;
    logic [2:0] exp_code;
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, a);
      acc.push_back(a);
      if (i == 0)
        chk({tag, "_busy_after_cmd"}, 32'(bus.busy), 32'(b[0] == 8'hA5 || b[0] == 8'h5A));
    end
    idle(int'(T) + 4);
    model(b, acc);
    exp_code = 3'd0;
    if (exp_ev.size() > 0 && exp_ev[exp_ev.size()-1].err) exp_code = exp_ev[exp_ev.size()-1].code;
    chk({tag, "_err_code_hold"}, 32'(bus.err_code), 32'(exp_code));
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check_frame(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    iq_t acc;
    int a, m, len, addr, depth;
    logic sel;

    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_wr_sel",   32'(bus.wr_sel),   32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    rst_n = 1'b1;
    chk("rdy_before_release_edge", 32'(bus.rx_ready), 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_release", 32'(bus.rx_ready), 32'd1);

    b = '{8'hA5, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h79};
    run_frame("sprite3", b, 0);
    b = '{8'h5A, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h3F, 8'h3F};
    run_frame("pal1", b, 0);
    b = '{8'h5A, 8'hFF, 8'h00, 8'h02, 8'h00};
    run_frame("pal_bounds", b, 0);
    b = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h07, 8'h08};
    run_frame("after_bounds", b, 0);
    b = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'h00};
    run_frame("bad_chk", b, 0);
    b = '{8'hA5, 8'h00};
    run_frame("timeout", b, 0);
    b = '{8'h00};
    run_frame("stray", b, 0);
    run_frame("sprite_top_edge", gen_frame(1'b0, 1020, 4, 1'b0), 0);
    run_frame("pal_top_edge", gen_frame(1'b1, 254, 2, 1'b0), 0);
    b = gen_frame(1'b1, 254, 3, 1'b0);
    while (b.size() > 5) void'(b.pop_back());
    run_frame("pal_over_edge", b, 0);
    b = gen_frame(1'b0, 0, 0, 1'b0);
    while (b.size() > 5) void'(b.pop_back());
    run_frame("len_zero", b, 0);

    // Reset in the middle of the data phase
    b = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11};
    acc.delete();
    for (int i = 0; i < b.size(); i++) begin send_byte(b[i], 0, a); acc.push_back(a); end
    exp_wr.push_back('{1'b0, 10'h000, 8'h11, acc[5]});
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst_busy",     32'(bus.busy),     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy_after", 32'(bus.rx_ready), 32'd1);
    idle(int'(T) + 4);
    check_frame("midrst");
    run_frame("post_rst", gen_frame(1'b0, 5, 2, 1'b0), 0);

    for (int i = 0; i < 30; i++) begin
      m     = int'($urandom_range(0, 9));
      sel   = 1'($urandom_range(0, 1));
      depth = sel ? 256 : 1024;
      len   = int'($urandom_range(1, 6));
      addr  = int'($urandom_range(0, depth - len));
      case (m)
        0: begin
          len  = int'($urandom_range(0, 6));
          addr = (len == 0) ? addr : depth - len + int'($urandom_range(1, 3));
          b = gen_frame(sel, addr, len, 1'b0);
          while (b.size() > 5) void'(b.pop_back());
        end
        1: b = gen_frame(sel, addr, len, 1'b1);
        2: begin
          b = gen_frame(sel, addr, len, 1'b0);
          m = int'($urandom_range(1, b.size() - 1));
          while (b.size() > m) void'(b.pop_back());
        end
        3: begin
          b.delete();
          do b.push_back(8'($urandom));
          while (0);
          if (b[0] == 8'hA5 || b[0] == 8'h5A) b[0] = 8'h3C;
        end
        default: b = gen_frame(sel, addr, len, 1'b0);
      endcase
      run_frame("rand", b, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/goose_loader.md
GOOSE_LOADER -- requirements
Module: goose_loader

Interface
REQ-001 Parameter SPRITE_DEPTH, default 1024, number of sprite index entries (32x32).
REQ-002 Parameter PALETTE_DEPTH, default 256, number of palette entries.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, max idle cycles between bytes inside a frame.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  loader can accept a byte; a byte is accepted when rx_valid && rx_ready.
REQ-009 wr_en  output  1  one-cycle memory write strobe.
REQ-010 wr_sel  output  1  0 = sprite index memory, 1 = palette memory.
REQ-011 wr_addr  output  10  write address (palette uses bits [7:0], bits [9:8] = 0).
REQ-012 wr_data  output  8  write data; palette byte packs {2'b00, R[1:0], G[1:0], B[1:0]}.
REQ-013 busy  output  1  high from accepted command byte until frame end.
REQ-014 done  output  1  one-cycle pulse, frame completed with good checksum.
REQ-015 err  output  1  one-cycle pulse, frame aborted or failed.
REQ-016 err_code  output  3  cause of last err; held until next valid command byte.

Function
REQ-017 Frame format SHALL be: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CHK.
REQ-018 CMD 0xA5 SHALL select sprite memory (wr_sel=0); CMD 0x5A SHALL select palette (wr_sel=1).
REQ-019 Any other byte in IDLE SHALL be discarded with err pulse, err_code=1; state stays IDLE.
REQ-020 States SHALL be IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CHECK; each accepted byte advances one state, except DATA, which stays until LEN bytes are accepted.
REQ-021 Address and length SHALL be little-endian 16-bit; only bits [9:0] are meaningful, upper bits must be 0.
REQ-022 After LEN_HI: if LEN==0, any upper bit set, or ADDR+LEN > depth of selected target, the frame SHALL abort to IDLE with err, err_code=2, and no write issued.
REQ-023 The k-th data byte (k=0..LEN-1) SHALL produce wr_en=1 exactly one cycle after acceptance, wr_addr=ADDR+k, wr_data=byte, wr_sel per CMD.
REQ-024 Writes SHALL NOT be buffered or undone; a later checksum failure leaves written data in place.
REQ-025 Checksum SHALL be 8-bit sum modulo 256 of ADDR_LO, ADDR_HI, LEN_LO, LEN_HI and all data bytes; CMD excluded.
REQ-026 CHK equal to sum SHALL give done pulse one cycle after CHK acceptance; mismatch SHALL give err, err_code=3; both return to IDLE.
REQ-027 In any non-IDLE state, TIMEOUT_CYCLES consecutive cycles without an accepted byte SHALL abort to IDLE with err, err_code=4; the counter restarts on each accepted byte.
REQ-028 rx_ready SHALL be 1 in all states except the single cycle in which done or err is driven from a non-IDLE state.
REQ-029 done and err SHALL never be asserted in the same cycle; wr_en is 0 whenever done or err is 1.
REQ-030 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-031 A valid CMD byte SHALL clear err_code to 0.

Reset
REQ-032 With rst_n=0 at a clock edge: state=IDLE, rx_ready=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, err_code=0, checksum and counters 0.
REQ-033 rx_ready SHALL rise the first cycle after rst_n returns high.
REQ-034 Reset mid-frame SHALL abandon the frame silently (no done/err); subsequent bytes are parsed from IDLE.

Verification
REQ-035 Sprite frame A5 10 00 03 00 11 22 33 79 -> writes (sel0) 0x010=11, 0x011=22, 0x012=33 on consecutive-byte cycles; done pulse; err never.
REQ-036 Palette frame 5A FF 00 01 00 3F 3F (sum 0xFF+0x01+0x3F=0x3F) -> single write sel1 addr 0xFF data 0x3F; done pulse.
REQ-037 Bounds: 5A FF 00 02 00 -> err_code=2 after LEN_HI, no wr_en; then A5 00 00 01 00 07 08 -> write 0x000=07, done.
REQ-038 Bad checksum A5 00 00 01 00 AA 00 -> write 0x000=AA, then err, err_code=3, no done.
REQ-039 Timeout with TIMEOUT_CYCLES=16: A5 00 then 16 idle cycles -> err, err_code=4, busy=0; stray byte 0x00 in IDLE -> err_code=1.
REQ-040 Reset during DATA of a 3-byte frame after 1 data byte -> no further wr_en, no done/err, rx_ready=0 in reset, 1 the cycle after release.
